// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and constants for spi_xfer_arbiter
// Imported by spi_rr_arbiter and spi_xfer_arbiter.
package spi_pkg;

  localparam int DATA_W       = 8;
  localparam int NUM_REQ      = 2;
  localparam int SHIFT_CYCLES = 9;
  localparam int CNT_W        = 4;
  localparam int GNT_W        = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    READ,
    FETCH,
    DONE
  } spi_xfer_state_t;

  function automatic logic [GNT_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [GNT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = GNT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - two-requester grant logic
// Round-robin when SPI_XFER_RR_EN is defined, fixed priority (requester 0 first) otherwise.
module spi_rr_arbiter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] gnt
);

`ifdef SPI_XFER_RR_EN
  // ptr_q names the requester that wins the next tie.
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt[ptr_q] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update && (|gnt)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt = '0;
    if (req[0]) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  logic unused_ctrl;
  assign unused_ctrl = clk ^ rst ^ update;
`endif

endmodule

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - arbitrates two requesters onto one SPI master with fixed 13-cycle latency
// Arbitration mode selected by SPI_XFER_RR_EN (see spi_rr_arbiter).
module spi_xfer_arbiter
  import spi_pkg::*;
(
  input  logic               mclk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  wdata0,
  input  logic [DATA_W-1:0]  wdata1,
  output logic [NUM_REQ-1:0] done,
  output logic [DATA_W-1:0]  rdata,
  output logic               busy,
  output logic               m_start,
  output logic               m_load,
  output logic               m_read,
  output logic [DATA_W-1:0]  m_data_in,
  input  logic [DATA_W-1:0]  m_data_out
);

  spi_xfer_state_t    state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [GNT_W-1:0]   gnt_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_update;

  // Requests are only looked at in IDLE, so a grant is frozen for the whole transfer.
  assign arb_update = (state_q == IDLE) && (|req);

  spi_rr_arbiter u_arb (
    .clk    (mclk),
    .rst    (rst),
    .req    (req),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_update) begin
            gnt_q   <= onehot_to_idx(arb_gnt);
            state_q <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(SHIFT_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= READ;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        READ: begin
          state_q <= FETCH;
        end
        FETCH: begin
          rdata_q <= m_data_out;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    m_start   = 1'b0;
    m_load    = 1'b0;
    m_read    = 1'b0;
    m_data_in = '0;
    done      = '0;
    case (state_q)
      LOAD: begin
        m_start   = 1'b1;
        m_load    = 1'b1;
        m_data_in = gnt_q[0] ? wdata1 : wdata0;
      end
      SHIFT: begin
        m_start = 1'b1;
      end
      READ: begin
        m_start = 1'b1;
        m_read  = 1'b1;
      end
      FETCH: begin
        m_read = 1'b1;
      end
      DONE: begin
        done[gnt_q] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - scoreboard bench for spi_xfer_arbiter with a loopback SPI master model
`timescale 1ns/1ps
module tb_spi_xfer_arbiter;

  logic       mclk = 1'b0;
  logic       rst  = 1'b1;
  logic [1:0] req  = 2'b00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  logic [1:0] done;
  logic [7:0] rdata;
  logic       busy;
  logic       m_start;
  logic       m_load;
  logic       m_read;
  logic [7:0] m_data_in;
  logic [7:0] m_data_out;

  spi_xfer_arbiter dut (
    .mclk       (mclk),
    .rst        (rst),
    .req        (req),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .done       (done),
    .rdata      (rdata),
    .busy       (busy),
    .m_start    (m_start),
    .m_load     (m_load),
    .m_read     (m_read),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [1:0] mask;
    logic [7:0] rd;
    int         due;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  int         m_cnt = 0;
  logic       ptr = 1'b0;
  logic       cur_valid = 1'b0;
  logic       cur_g = 1'b0;
  logic [7:0] cur_w = 8'h00;
  int         grant_cyc = 0;
  int         k;
  logic       act;
  logic [7:0] hold = 8'h00;
  logic [7:0] fetch_val = 8'h00;
  logic [7:0] sr;
  logic [7:0] mdout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] rotl1(input logic [7:0] w);
    return {w[6:0], w[7]};
  endfunction

  function automatic logic pick(input logic [1:0] r, input logic p);
`ifdef SPI_XFER_RR_EN
    return (r == 2'b11) ? p : r[1];
`else
    return r[0] ? 1'b0 : 1'b1;
`endif
  endfunction

  // Loopback master: miso tied to mosi, MSB first, so each shift rotates left.
  assign m_data_out = mdout;
  always @(posedge mclk or posedge rst) begin
    if (rst) begin
      sr    <= 8'h00;
      mdout <= 8'h00;
    end else begin
      if (m_load) sr <= m_data_in;
      else if (m_start && !m_read) sr <= {sr[6:0], sr[7]};
      if (m_start && m_read) mdout <= sr;
    end
  end

  // Reference model: grant decision and expected completion pushed at the sampling edge.
  initial forever begin
    @(posedge mclk);
    cyc++;
    if (rst) begin
      m_cnt     = 0;
      ptr       = 1'b0;
      cur_valid = 1'b0;
      sb.delete();
    end else if (m_cnt == 0) begin
      if (req != 2'b00) begin
        cur_g     = pick(req, ptr);
        cur_w     = cur_g ? wdata1 : wdata0;
        cur_valid = 1'b1;
        grant_cyc = cyc;
        m_cnt     = 13;
        sb.push_back('{mask: (cur_g ? 2'b10 : 2'b01), rd: rotl1(cur_w), due: cyc + 12});
`ifdef SPI_XFER_RR_EN
        ptr = ~cur_g;
`endif
      end
    end else begin
      m_cnt--;
    end
  end

  // Per-cycle monitor: strobe timeline and scoreboard pop on done.
  initial forever begin
    @(negedge mclk);
    if (rst) begin
      hold = 8'h00;
    end else begin
      k   = cyc - grant_cyc;
      act = cur_valid && (k <= 12);
      check_eq("busy", busy, act);
      check_eq("m_start", m_start, act && (k <= 10));
      check_eq("m_load", m_load, act && (k == 0));
      check_eq("m_read", m_read, act && (k == 10 || k == 11));
      check_eq("m_data_in", m_data_in, (act && k == 0) ? cur_w : 8'h00);
      check_eq("done", done, (act && k == 12) ? (cur_g ? 2'b10 : 2'b01) : 2'b00);
      if (m_read && !m_start) fetch_val = m_data_out;
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          check_eq("done_unexpected", done, 0);
        end else begin
          e = sb.pop_front();
          check_eq("sb_mask", done, e.mask);
          check_eq("sb_cycle", cyc, e.due);
          check_eq("sb_rdata", rdata, e.rd);
          check_eq("rdata_vs_master", rdata, fetch_val);
          hold = e.rd;
        end
      end else begin
        check_eq("rdata_hold", rdata, hold);
      end
    end
  end

  task automatic wait_done(output logic [1:0] d, output int c);
    d = 2'b00;
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge mclk);
      if (done != 2'b00) begin
        d = done;
        c = cyc;
        break;
      end
    end
    if (d == 2'b00) check_eq("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_m_start"}, m_start, 0);
    check_eq({tag, "_m_load"}, m_load, 0);
    check_eq({tag, "_m_read"}, m_read, 0);
    check_eq({tag, "_m_data_in"}, m_data_in, 0);
    check_eq({tag, "_rdata"}, rdata, 0);
  endtask

  initial begin
    logic [1:0] d;
    logic [1:0] order [4];
    logic [1:0] exp_order [4];
    int         c;
    int         c_prev;
    int         n_done;

`ifdef SPI_XFER_RR_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge mclk);
    #2 rst = 1'b0;

    // Single request from requester 0.
    @(negedge mclk);
    wdata0 = 8'hA5;
    req    = 2'b01;
    wait_done(d, c);
    check_eq("t1_done", d, 2'b01);
    check_eq("t1_rdata", rdata, 8'h4B);
    req = 2'b00;
    repeat (2) @(negedge mclk);
    check_eq("t1_idle_busy", busy, 0);

    // Loopback on requester 1.
    @(negedge mclk);
    wdata1 = 8'h3C;
    req    = 2'b10;
    wait_done(d, c);
    check_eq("t2_done", d, 2'b10);
    check_eq("t2_rdata", rdata, 8'h78);
    req = 2'b00;
    repeat (3) @(negedge mclk);

    // Contention with both requests held.
    wdata0 = 8'h11;
    wdata1 = 8'h22;
    req    = 2'b11;
    c_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done(d, c);
      order[i] = d;
      if (i > 0) check_eq("t3_spacing", c - c_prev, 14);
      c_prev = c;
    end
    req = 2'b00;
    for (int i = 0; i < 4; i++) check_eq("t3_order", order[i], exp_order[i]);
    repeat (3) @(negedge mclk);

    // Requester 1 rises during requester 0's SHIFT.
    wdata0 = 8'h81;
    req    = 2'b01;
    repeat (5) @(negedge mclk);
    wdata1 = 8'h7E;
    req    = 2'b11;
    wait_done(d, c);
    check_eq("t4_first", d, 2'b01);
    req    = 2'b10;
    c_prev = c;
    wait_done(d, c);
    check_eq("t4_second", d, 2'b10);
    check_eq("t4_spacing", c - c_prev, 14);
    req = 2'b00;
    repeat (3) @(negedge mclk);

    // Reset in cycle 6 of a transfer.
    wdata0 = 8'hC3;
    req    = 2'b01;
    repeat (6) @(negedge mclk);
    check_eq("t5_in_shift", m_start && !m_load && !m_read, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t5_rst");
    @(negedge mclk);
    req = 2'b00;
    #2 rst = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge mclk);
      if (done != 2'b00) n_done++;
    end
    check_eq("t5_no_done", n_done, 0);

    // Fresh contention after reset: pointer favours requester 0 again.
    wdata0 = 8'h5A;
    wdata1 = 8'h99;
    req    = 2'b11;
    wait_done(d, c);
    check_eq("t6_first", d, 2'b01);
    check_eq("t6_rdata0", rdata, 8'hB4);
    req = 2'b10;
    wait_done(d, c);
    check_eq("t6_second", d, 2'b10);
    check_eq("t6_rdata1", rdata, 8'h33);
    req = 2'b00;
    repeat (2) @(negedge mclk);

    // Random traffic.
    for (int i = 0; i < 8; i++) begin
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      req    = 2'($urandom_range(1, 3));
      wait_done(d, c);
      req = req & ~d;
      if (req != 2'b00) begin
        wait_done(d, c);
        req = req & ~d;
      end
      repeat (2) @(negedge mclk);
    end

    repeat (5) @(negedge mclk);
    check_eq("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 mclk  input  1  system clock; the SPI master's sclk is derived from it; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req  input  2  per-requester transfer request; held high until that requester's done pulse.
REQ-005 wdata0, wdata1  input  8 each  transmit byte per requester; held stable while the matching req is high.
REQ-006 done  output  2  one-cycle completion pulse per requester.
REQ-007 rdata  output  8  received byte; valid while done is high; held until the next transfer completes.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 m_start, m_load, m_read  output  1 each  control strobes to the SPI master.
REQ-010 m_data_in  output  8  byte loaded into the master.
REQ-011 m_data_out  input  8  master's data output; meaningful only while m_read is high.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, SHIFT, READ, FETCH and DONE.
REQ-013 In IDLE with req nonzero, the grant SHALL be registered and the FSM SHALL go to LOAD; with req zero it SHALL stay in IDLE.
REQ-014 LOAD SHALL last 1 cycle with m_start=1, m_load=1 and m_data_in equal to the granted requester's wdata.
REQ-015 SHIFT SHALL last exactly SHIFT_CYCLES (9) cycles with m_start=1, m_load=0 and m_read=0, counted by a 4-bit counter.
REQ-016 READ SHALL last 1 cycle with m_start=1 and m_read=1, so that the master captures its shift register.
REQ-017 FETCH SHALL last 1 cycle with m_start=0 and m_read=1, and rdata SHALL load m_data_out at the end of FETCH.
REQ-018 DONE SHALL last 1 cycle, asserting done[granted], then return to IDLE.
REQ-019 The strobe outputs SHALL be combinational decodes of the state, and m_data_in SHALL be 0 outside LOAD.
REQ-020 Latency SHALL be fixed: the edge that samples req in IDLE is followed by done high in cycle 13.
REQ-021 The arbiter SHALL evaluate req only in IDLE; req changes during a transfer SHALL NOT alter the grant or the sequence.
REQ-022 A granted requester dropping req mid-transfer SHALL still receive its done pulse and updated rdata.
REQ-023 The minimum spacing between consecutive grants SHALL be 14 cycles, because the IDLE cycle after DONE is mandatory.
REQ-024 At most one done bit SHALL be high in any cycle.

Reset
REQ-025 Asserting rst SHALL immediately force state to IDLE, counter to 0, grant to requester 0 and the RR pointer to 0.
REQ-026 Asserting rst SHALL also force rdata=0x00 and done, busy and all m_* outputs to 0, including when asserted mid-transfer.
REQ-027 After a mid-transfer reset, no done pulse SHALL be issued for the aborted transfer.

Configuration
REQ-028 With SPI_XFER_RR_EN defined, arbitration SHALL be round-robin: on a tie the requester not granted last wins, and the pointer updates on each grant.
REQ-029 After reset with SPI_XFER_RR_EN defined, the pointer SHALL favour requester 0.
REQ-030 Without SPI_XFER_RR_EN, arbitration SHALL be fixed priority: requester 0 always beats requester 1.

Structure
REQ-031 The shared package spi_pkg SHALL hold the state enum spi_xfer_state_t, SHIFT_CYCLES=9, NUM_REQ=2 and the 8-bit data width constant.
REQ-032 The grant logic SHALL be a sub-module spi_rr_arbiter (req, update, gnt) whose internal pointer exists only under SPI_XFER_RR_EN.

Verification
REQ-033 Single request: req=01, wdata0=0xA5 -> m_load high for 1 cycle with m_data_in=0xA5; m_start high for 11 cycles; done=01 in cycle 13; busy low afterwards.
REQ-034 Loopback: master miso tied to mosi, wdata1=0x3C, req=10 -> rdata equals the master's captured byte, checked against the master's data_out during FETCH, and is stable until the next done.
REQ-035 Contention with RR enabled: req=11 held continuously -> done order 01, 10, 01, 10, with each grant 14 cycles apart.
REQ-036 Contention with RR disabled: req=11 held continuously -> done always 01 and requester 1 is starved.
REQ-037 Reset mid-SHIFT: rst pulsed at cycle 6 of a transfer -> all outputs 0 in that cycle, no done pulse, and a fresh request afterwards completes normally.
REQ-038 Late request: req1 rises during requester 0's SHIFT -> it is ignored until IDLE, then granted with done=10 exactly 14 cycles after done=01.
